// File: rtl/demux_pkg.sv
// Shared constants and state encoding for the demux scheduler.
package demux_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } sched_state_t;
endpackage

// File: rtl/demux_next_ch.sv
// Priority encoder: lowest set bit of the remaining-channel mask.
module demux_next_ch
  import demux_pkg::*;
(
  input  logic [NUM_CH-1:0] rem_mask_i,
  output logic [SEL_W-1:0]  idx_o,
  output logic              none_o
);

  always_comb begin
    idx_o  = '0;
    none_o = 1'b1;
    // Scan downward so the lowest set bit is the one that sticks.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rem_mask_i[i]) begin
        idx_o  = SEL_W'(i);
        none_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/demux_scheduler.sv
// Frame sequencer for the 1-to-4 bit demux: accepts a word, then walks
// the enabled channels in ascending order, holding each for DWELL cycles.
module demux_scheduler
  import demux_pkg::*;
#(
  parameter int DWELL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [NUM_CH-1:0] s_data,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              d_in,
  output logic [SEL_W-1:0]  d_sel,
  output logic              d_active,
  output logic              busy,
  output logic              frame_done
);

  localparam int              CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  sched_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] rem_q, rem_d;
  logic [NUM_CH-1:0] data_q;
  logic              load;
  logic              s_ready_q, s_ready_d;
  logic              d_in_q, d_in_d;
  logic [SEL_W-1:0]  d_sel_q, d_sel_d;
  logic              d_active_q, d_active_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [NUM_CH-1:0] scan_mask;
  logic [SEL_W-1:0]  nxt_idx;
  logic              nxt_none;
  logic [NUM_CH-1:0] nxt_onehot;

  // One encoder serves both the first pick at accept and every advance.
  assign scan_mask  = (state_q == IDLE) ? ch_mask : rem_q;
  assign nxt_onehot = NUM_CH'(1) << nxt_idx;

  demux_next_ch u_next_ch (
    .rem_mask_i (scan_mask),
    .idx_o      (nxt_idx),
    .none_o     (nxt_none)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    load       = 1'b0;
    s_ready_d  = 1'b0;
    d_in_d     = 1'b0;
    d_sel_d    = '0;
    d_active_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (s_valid && s_ready_q) begin
          load   = 1'b1;
          cnt_d  = '0;
          busy_d = 1'b1;
          if (!nxt_none) begin
            state_d    = SEND;
            d_active_d = 1'b1;
            d_sel_d    = nxt_idx;
            d_in_d     = s_data[nxt_idx];
            rem_d      = ch_mask & ~nxt_onehot;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            rem_d   = '0;
          end
        end else begin
          s_ready_d = 1'b1;
        end
      end

      SEND: begin
        busy_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (nxt_none) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            d_active_d = 1'b1;
            d_sel_d    = nxt_idx;
            d_in_d     = data_q[nxt_idx];
            rem_d      = rem_q & ~nxt_onehot;
          end
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
          d_active_d = 1'b1;
          d_sel_d    = d_sel_q;
          d_in_d     = d_in_q;
        end
      end

      DONE: begin
        state_d   = IDLE;
        s_ready_d = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      s_ready_q  <= 1'b0;
      d_in_q     <= 1'b0;
      d_sel_q    <= '0;
      d_active_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      s_ready_q  <= s_ready_d;
      d_in_q     <= d_in_d;
      d_sel_q    <= d_sel_d;
      d_active_q <= d_active_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Word payload is only read while the FSM says it is valid.
  always_ff @(posedge clk) begin
    if (load) begin
      data_q <= s_data;
    end
  end

  assign s_ready    = s_ready_q;
  assign d_in       = d_in_q;
  assign d_sel      = d_sel_q;
  assign d_active   = d_active_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_demux_scheduler.sv
// Bench for demux_scheduler: two instances (DWELL=1 and DWELL=3) checked
// against a per-cycle scoreboard built from each accepted word.
module tb_demux_scheduler;

  typedef struct packed {
    logic       rdy;
    logic       act;
    logic [1:0] sel;
    logic       din;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct {
    int         u;
    logic [3:0] data;
    logic [3:0] mask;
    int         exp_len;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid [2];
  logic [3:0] s_data  [2];
  logic [3:0] ch_mask [2];
  logic       s_ready [2];
  logic       d_in    [2];
  logic [1:0] d_sel   [2];
  logic       d_active[2];
  logic       busy    [2];
  logic       frame_done[2];

  int   errors = 0;
  int   checks = 0;
  obs_t sb[$];
  vec_t vecs[7];

  always #5 clk = ~clk;

  demux_scheduler #(.DWELL(1)) u_d1 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .s_data(s_data[0]), .ch_mask(ch_mask[0]),
    .d_in(d_in[0]), .d_sel(d_sel[0]), .d_active(d_active[0]),
    .busy(busy[0]), .frame_done(frame_done[0])
  );

  demux_scheduler #(.DWELL(3)) u_d3 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .s_data(s_data[1]), .ch_mask(ch_mask[1]),
    .d_in(d_in[1]), .d_sel(d_sel[1]), .d_active(d_active[1]),
    .busy(busy[1]), .frame_done(frame_done[1])
  );

  function automatic int dwell_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  function automatic obs_t observe(input int u);
    obs_t o;
    o.rdy  = s_ready[u];
    o.act  = d_active[u];
    o.sel  = d_sel[u];
    o.din  = d_in[u];
    o.busy = busy[u];
    o.done = frame_done[u];
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got rdy=%b act=%b sel=%0d din=%b busy=%b done=%b, expected rdy=%b act=%b sel=%0d din=%b busy=%b done=%b",
               name, got.rdy, got.act, got.sel, got.din, got.busy, got.done,
               exp.rdy, exp.act, exp.sel, exp.din, exp.busy, exp.done);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Expected cycle-by-cycle outputs of one frame, starting the cycle after accept.
  task automatic push_frame(input int u, input logic [3:0] data, input logic [3:0] mask);
    obs_t e;
    for (int c = 0; c < 4; c++) begin
      if (mask[c]) begin
        for (int k = 0; k < dwell_of(u); k++) begin
          e = '{rdy: 1'b0, act: 1'b1, sel: 2'(c), din: data[c], busy: 1'b1, done: 1'b0};
          sb.push_back(e);
        end
      end
    end
    e = '{rdy: 1'b0, act: 1'b0, sel: 2'd0, din: 1'b0, busy: 1'b1, done: 1'b1};
    sb.push_back(e);
    e = '{rdy: 1'b1, act: 1'b0, sel: 2'd0, din: 1'b0, busy: 1'b0, done: 1'b0};
    sb.push_back(e);
  endtask

  task automatic wait_ready(input int u);
    int n;
    n = 0;
    @(negedge clk);
    while (!s_ready[u] && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!s_ready[u]) begin
      errors++;
      $display("FAIL wait_ready u%0d: got s_ready=0 after %0d cycles, expected 1", u, n);
    end
  endtask

  task automatic run_frame(input int u, input logic [3:0] data, input logic [3:0] mask,
                           input int exp_len, input string name);
    int   n_act;
    obs_t e;
    wait_ready(u);
    s_valid[u] = 1'b1;
    s_data[u]  = data;
    ch_mask[u] = mask;
    push_frame(u, data, mask);
    @(posedge clk);
    #1;
    s_valid[u] = 1'b0;
    s_data[u]  = ~data;
    ch_mask[u] = ~mask;
    n_act = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      if (d_active[u]) n_act++;
      check(name, observe(u), e);
    end
    check_int({name, "_active_len"}, n_act, exp_len);
  endtask

  initial begin
    obs_t zero;
    obs_t idle;
    int   n_acc;
    int   acc_at[2];
    int   n;

    zero = '0;
    idle = '{rdy: 1'b1, act: 1'b0, sel: 2'd0, din: 1'b0, busy: 1'b0, done: 1'b0};
    for (int u = 0; u < 2; u++) begin
      s_valid[u] = 1'b0;
      s_data[u]  = 4'h0;
      ch_mask[u] = 4'h0;
    end

    vecs[0] = '{0, 4'b1010, 4'b1111, 4,  "full_d1"};
    vecs[1] = '{1, 4'b0100, 4'b0101, 6,  "sparse_d3"};
    vecs[2] = '{0, 4'b0110, 4'b0000, 0,  "empty_d1"};
    vecs[3] = '{1, 4'b1111, 4'b1000, 3,  "ch3_d3"};
    vecs[4] = '{0, 4'b0101, 4'b0110, 2,  "mid_d1"};
    vecs[5] = '{1, 4'b1010, 4'b1111, 12, "full_d3"};
    vecs[6] = '{1, 4'b0000, 4'b0000, 0,  "empty_d3"};

    // Power-on reset, then release: ready after exactly one edge.
    repeat (2) @(negedge clk);
    check("por_d1", observe(0), zero);
    check("por_d3", observe(1), zero);
    #1 rst_n = 1'b1;
    #1 check("rel_pre_edge", observe(0), zero);
    @(posedge clk);
    #1;
    check("rel_ready_d1", observe(0), idle);
    check("rel_ready_d3", observe(1), idle);

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].u, vecs[i].data, vecs[i].mask, vecs[i].exp_len, vecs[i].name);
    end

    // Back-to-back frames with s_valid held high; ch_mask wiggles mid-frame.
    wait_ready(0);
    s_valid[0] = 1'b1;
    s_data[0]  = 4'hF;
    ch_mask[0] = 4'hF;
    push_frame(0, 4'hF, 4'hF);
    push_frame(0, 4'h0, 4'hF);
    n_acc = 0;
    acc_at[0] = -1;
    acc_at[1] = -1;
    for (int i = 0; i < 13; i++) begin
      if (i > 0) begin
        @(negedge clk);
        check("b2b", observe(0), sb.pop_front());
      end
      if (s_valid[0] && s_ready[0]) begin
        if (n_acc < 2) acc_at[n_acc] = i;
        n_acc++;
      end
      @(posedge clk);
      #1;
      if (n_acc == 1) s_data[0] = 4'h0;
      if (n_acc == 2) s_valid[0] = 1'b0;
      if (i == 1) ch_mask[0] = 4'b0001;
      if (i == 3) ch_mask[0] = 4'hF;
    end
    check_int("b2b_accepts", n_acc, 2);
    check_int("b2b_period", acc_at[1] - acc_at[0], 6);

    // Asynchronous reset during channel 2 of a full frame.
    wait_ready(0);
    s_valid[0] = 1'b1;
    s_data[0]  = 4'hF;
    ch_mask[0] = 4'hF;
    @(posedge clk);
    #1 s_valid[0] = 1'b0;
    n = 0;
    while (!(d_active[0] && d_sel[0] == 2'd2) && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_int("midrst_reached_ch2", int'(d_sel[0]), 2);
    #1 rst_n = 1'b0;
    #1 check("midrst_async", observe(0), zero);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("midrst_hold_d1", observe(0), zero);
      check("midrst_hold_d3", observe(1), zero);
    end
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 check("midrst_release", observe(0), idle);
    run_frame(0, 4'b0001, 4'hF, 4, "restart_d1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
